// File: rtl/add_sub_seq.sv
// add_sub_seq: block-serial adder/subtractor, one BLK-bit slice per clock with a registered inter-block carry.
// Define ADDSUB_OVF_EN to build the signed-overflow flag; otherwise o_ovf is tied to 0.
module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);
  localparam int NBLK = WIDTH / BLK;
  localparam int IW   = NBLK > 1 ? $clog2(NBLK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum, w_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry, r_cout, r_zero;
  logic [BLK-1:0]   w_sa, w_sb;
  logic [BLK:0]     w_rip;
  logic             w_carry, w_last, w_acc;
  assign w_sa    = r_a[r_idx*BLK +: BLK];
  assign w_sb    = r_b[r_idx*BLK +: BLK];
  assign w_rip   = {1'b0, w_sa} + {1'b0, w_sb} + {{BLK{1'b0}}, r_carry};
  // a fully propagating slice passes its carry-in straight through (same value as the ripple)
  assign w_carry = &(w_sa ^ w_sb) ? r_carry : w_rip[BLK];
  assign w_last  = r_idx == IW'(NBLK - 1);
  assign w_acc   = i_in_valid && r_state == IDLE;
  always_comb begin
    w_sum = r_sum;
    w_sum[r_idx*BLK +: BLK] = w_rip[BLK-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (i_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_acc) begin
      r_a     <= i_a;
      r_b     <= i_b ^ {WIDTH{i_sub}};
      r_carry <= i_sub;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum;
      r_carry <= w_carry;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_carry;
        r_zero <= w_sum == '0;
      end
    end
  end
`ifdef ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf;
  // carry into the MSB recovered from the MSB sum bit and its operand bits
  assign w_ovf = (w_sa[BLK-1] ^ w_sb[BLK-1] ^ w_rip[BLK-1]) ^ w_carry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= w_ovf;
  end
  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif
  assign o_in_ready  = r_state == IDLE;
  assign o_out_valid = r_state == DONE;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_zero      = r_zero;
endmodule
